// File: rtl/mem_map_pkg.sv
// Address map, status bit positions and the address decoder shared by the
// data-memory responder.
package mem_map_pkg;

   localparam logic [3:0]  MMIO_PAGE    = 4'hF;
   localparam logic [31:0] CONSOLE_ADDR = 32'hF000_0000;
   localparam logic [31:0] STATUS_ADDR  = 32'hF000_0004;
   localparam logic [31:0] CYCLE_ADDR   = 32'hF000_0008;
   localparam logic [31:0] TOHOST_ADDR  = 32'hF000_000C;

   localparam int unsigned STATUS_EMPTY_BIT = 0;
   localparam int unsigned STATUS_FULL_BIT  = 1;
   localparam int unsigned STATUS_OVF_BIT   = 2;

   typedef enum logic [2:0] {
      SEL_RAM,
      SEL_CONSOLE,
      SEL_STATUS,
      SEL_CYCLE,
      SEL_TOHOST,
      SEL_NONE
   } sel_e;

   // Takes the word address (byte address bits [31:2]); byte offset never matters.
   function automatic sel_e decode(input logic [29:0] word_addr);
      sel_e result;
      if (word_addr[29:26] != MMIO_PAGE)          result = SEL_RAM;
      else if (word_addr == CONSOLE_ADDR[31:2])   result = SEL_CONSOLE;
      else if (word_addr == STATUS_ADDR[31:2])    result = SEL_STATUS;
      else if (word_addr == CYCLE_ADDR[31:2])     result = SEL_CYCLE;
      else if (word_addr == TOHOST_ADDR[31:2])    result = SEL_TOHOST;
      else                                        result = SEL_NONE;
      return result;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO; a push while full is accepted only when a pop frees the
// slot in the same cycle. Head data reads as zero while empty.
module sync_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         din,
   output logic [WIDTH-1:0]         dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned PW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == DEPTH[PW:0]);
   assign empty   = (count == '0);
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign dout    = empty ? '0 : mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: word RAM with combinational read plus an MMIO page
// holding the console FIFO, a cycle counter and the tohost halt register.
module data_mem_responder
   import mem_map_pkg::*;
#(
   parameter int unsigned RAM_WORDS  = 256,
   parameter int unsigned FIFO_DEPTH = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        MemWrite,
   input  logic [31:0] ALUResult,
   input  logic [31:0] WriteData,
   output logic [31:0] ReadData,
   output logic        cons_valid,
   input  logic        cons_ready,
   output logic [7:0]  cons_data,
   output logic        halt,
   output logic [31:0] exit_code
);

   localparam int unsigned AW = $clog2(RAM_WORDS);

   logic [31:0]                 ram [RAM_WORDS];
   logic [AW-1:0]               ram_idx;
   sel_e                        sel;
   logic                        wr_en;
   logic                        cons_push;
   logic                        cons_pop;
   logic                        fifo_full;
   logic                        fifo_empty;
   logic [$clog2(FIFO_DEPTH):0] unused_count;
   logic                        unused_offset;
   logic                        overflow;
   logic [31:0]                 cycle_count;
   logic [31:0]                 status_word;

   assign sel           = decode(ALUResult[31:2]);
   assign ram_idx       = ALUResult[AW+1:2];
   assign unused_offset = ^ALUResult[1:0];

   // Halt freezes every architectural write; reads and the drain keep going.
   assign wr_en      = MemWrite & ~halt & ~reset;
   assign cons_push  = wr_en & (sel == SEL_CONSOLE);
   assign cons_valid = ~fifo_empty;
   assign cons_pop   = cons_valid & cons_ready;

   sync_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_cons_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (cons_push),
      .pop   (cons_pop),
      .din   (WriteData[7:0]),
      .dout  (cons_data),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (unused_count)
   );

   always_ff @(posedge clk) begin
      if (wr_en && sel == SEL_RAM) ram[ram_idx] <= WriteData;
   end

   always_ff @(posedge clk) begin
      if (reset)                            overflow <= 1'b0;
      else if (wr_en && sel == SEL_STATUS)  overflow <= 1'b0;
      else if (cons_push && fifo_full && !cons_pop) overflow <= 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset)                           cycle_count <= '0;
      else if (wr_en && sel == SEL_CYCLE)  cycle_count <= WriteData;
      else                                 cycle_count <= cycle_count + 32'd1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         halt      <= 1'b0;
         exit_code <= '0;
      end else if (wr_en && sel == SEL_TOHOST) begin
         halt      <= 1'b1;
         exit_code <= WriteData;
      end
   end

   always_comb begin
      status_word                   = '0;
      status_word[STATUS_EMPTY_BIT] = fifo_empty;
      status_word[STATUS_FULL_BIT]  = fifo_full;
      status_word[STATUS_OVF_BIT]   = overflow;
   end

   always_comb begin
      ReadData = '0;
      case (sel)
         SEL_RAM:    ReadData = ram[ram_idx];
         SEL_STATUS: ReadData = status_word;
         SEL_CYCLE:  ReadData = cycle_count;
         SEL_TOHOST: ReadData = exit_code;
         default:    ReadData = '0;
      endcase
   end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: RAM, console FIFO, overflow,
// cycle counter, halt and mid-drain reset.
module tb_data_mem_responder;

   localparam logic [31:0] A_CONSOLE = 32'hF000_0000;
   localparam logic [31:0] A_STATUS  = 32'hF000_0004;
   localparam logic [31:0] A_CYCLE   = 32'hF000_0008;
   localparam logic [31:0] A_TOHOST  = 32'hF000_000C;

   logic        clk;
   logic        reset;
   logic        MemWrite;
   logic [31:0] ALUResult;
   logic [31:0] WriteData;
   logic [31:0] ReadData;
   logic        cons_valid;
   logic        cons_ready;
   logic [7:0]  cons_data;
   logic        halt;
   logic [31:0] exit_code;

   int unsigned errors = 0;
   int unsigned checks = 0;

   data_mem_responder #(
      .RAM_WORDS  (256),
      .FIFO_DEPTH (8)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .MemWrite   (MemWrite),
      .ALUResult  (ALUResult),
      .WriteData  (WriteData),
      .ReadData   (ReadData),
      .cons_valid (cons_valid),
      .cons_ready (cons_ready),
      .cons_data  (cons_data),
      .halt       (halt),
      .exit_code  (exit_code)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      ALUResult = a;
      WriteData = d;
      MemWrite  = 1'b1;
      tick();
      MemWrite  = 1'b0;
   endtask

   task automatic rd(input logic [31:0] a, output logic [31:0] d);
      ALUResult = a;
      MemWrite  = 1'b0;
      #1;
      d = ReadData;
   endtask

   task automatic apply_reset();
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      logic [31:0] d;
      reset = 1'b1;
      tick();
      tick();
      checks++; if (cons_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", cons_valid); end
      checks++; if (cons_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", cons_data); end
      checks++; if (halt !== 1'b0) begin errors++; $display("FAIL reset_halt: got %b want 0", halt); end
      checks++; if (exit_code !== 32'h0) begin errors++; $display("FAIL reset_exit: got %h want 0", exit_code); end
      rd(A_STATUS, d);
      checks++; if (d !== 32'h1) begin errors++; $display("FAIL reset_status: got %h want 00000001", d); end
      rd(A_CYCLE, d);
      checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_cycle: got %h want 0", d); end
      reset = 1'b0;
      tick(); tick(); tick();
      rd(A_CYCLE, d);
      checks++; if (d !== 32'd3) begin errors++; $display("FAIL cycle_after_reset: got %h want 3", d); end
   endtask

   task automatic test_ram();
      logic [31:0] d;
      wr(32'h40, 32'h1234_5678);
      rd(32'h40, d);
      checks++; if (d !== 32'h1234_5678) begin errors++; $display("FAIL ram_read: got %h want 12345678", d); end
      rd(32'h43, d);
      checks++; if (d !== 32'h1234_5678) begin errors++; $display("FAIL ram_unaligned: got %h want 12345678", d); end
      ALUResult = 32'h40;
      WriteData = 32'hDEAD_BEEF;
      MemWrite  = 1'b1;
      #1;
      checks++; if (ReadData !== 32'h1234_5678) begin errors++; $display("FAIL ram_old_on_write: got %h want 12345678", ReadData); end
      tick();
      MemWrite = 1'b0;
      rd(32'h40, d);
      checks++; if (d !== 32'hDEAD_BEEF) begin errors++; $display("FAIL ram_new: got %h want deadbeef", d); end
      rd(32'h440, d);
      checks++; if (d !== 32'hDEAD_BEEF) begin errors++; $display("FAIL ram_alias: got %h want deadbeef", d); end
      rd(32'hF000_0010, d);
      checks++; if (d !== 32'h0) begin errors++; $display("FAIL mmio_unmapped: got %h want 0", d); end
   endtask

   task automatic test_console();
      logic [31:0] d;
      cons_ready = 1'b0;
      checks++; if (cons_valid !== 1'b0) begin errors++; $display("FAIL cons_idle: got %b want 0", cons_valid); end
      wr(A_CONSOLE, 32'h0000_0041);
      checks++; if (cons_valid !== 1'b1 || cons_data !== 8'h41) begin errors++; $display("FAIL cons_first: got v=%b d=%h want v=1 d=41", cons_valid, cons_data); end
      wr(A_CONSOLE, 32'hFFFF_FF42);
      checks++; if (cons_data !== 8'h41) begin errors++; $display("FAIL cons_hold: got %h want 41", cons_data); end
      rd(A_CONSOLE, d);
      checks++; if (d !== 32'h0) begin errors++; $display("FAIL cons_read: got %h want 0", d); end
      cons_ready = 1'b1;
      tick();
      checks++; if (cons_valid !== 1'b1 || cons_data !== 8'h42) begin errors++; $display("FAIL cons_second: got v=%b d=%h want v=1 d=42", cons_valid, cons_data); end
      tick();
      checks++; if (cons_valid !== 1'b0 || cons_data !== 8'h00) begin errors++; $display("FAIL cons_drained: got v=%b d=%h want v=0 d=00", cons_valid, cons_data); end
      cons_ready = 1'b0;
   endtask

   task automatic test_overflow();
      logic [31:0] d;
      logic [7:0]  exp;
      cons_ready = 1'b0;
      for (int i = 0; i < 8; i++) wr(A_CONSOLE, 32'h10 + i);
      rd(A_STATUS, d);
      checks++; if (d !== 32'h2) begin errors++; $display("FAIL ovf_full: got %h want 2", d); end
      wr(A_CONSOLE, 32'h18);
      rd(A_STATUS, d);
      checks++; if (d !== 32'h6) begin errors++; $display("FAIL ovf_set: got %h want 6", d); end
      wr(A_STATUS, 32'h0);
      rd(A_STATUS, d);
      checks++; if (d !== 32'h2) begin errors++; $display("FAIL ovf_clear: got %h want 2", d); end
      cons_ready = 1'b1;
      wr(A_CONSOLE, 32'h77);
      cons_ready = 1'b0;
      rd(A_STATUS, d);
      checks++; if (d !== 32'h2) begin errors++; $display("FAIL push_pop_full: got %h want 2", d); end
      cons_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         exp = (i == 7) ? 8'h77 : 8'(8'h11 + i);
         checks++; if (cons_valid !== 1'b1 || cons_data !== exp) begin errors++; $display("FAIL drain_%0d: got v=%b d=%h want v=1 d=%h", i, cons_valid, cons_data, exp); end
         tick();
      end
      checks++; if (cons_valid !== 1'b0) begin errors++; $display("FAIL drain_empty: got %b want 0", cons_valid); end
      cons_ready = 1'b0;
   endtask

   task automatic test_counter();
      logic [31:0] d;
      wr(A_CYCLE, 32'hFFFF_FFFE);
      rd(A_CYCLE, d);
      checks++; if (d !== 32'hFFFF_FFFE) begin errors++; $display("FAIL cycle_load: got %h want fffffffe", d); end
      tick();
      rd(A_CYCLE, d);
      checks++; if (d !== 32'hFFFF_FFFF) begin errors++; $display("FAIL cycle_inc: got %h want ffffffff", d); end
      tick();
      rd(A_CYCLE, d);
      checks++; if (d !== 32'h0) begin errors++; $display("FAIL cycle_wrap: got %h want 0", d); end
   endtask

   task automatic test_halt();
      logic [31:0] d;
      cons_ready = 1'b0;
      wr(32'h80, 32'h5555_5555);
      wr(A_CONSOLE, 32'h61);
      wr(A_CONSOLE, 32'h62);
      wr(A_TOHOST, 32'h2A);
      checks++; if (halt !== 1'b1 || exit_code !== 32'h2A) begin errors++; $display("FAIL halt_set: got h=%b e=%h want h=1 e=2a", halt, exit_code); end
      rd(A_TOHOST, d);
      checks++; if (d !== 32'h2A) begin errors++; $display("FAIL tohost_read: got %h want 2a", d); end
      wr(32'h80, 32'hAAAA_AAAA);
      wr(A_TOHOST, 32'h99);
      wr(A_CONSOLE, 32'h63);
      rd(32'h80, d);
      checks++; if (d !== 32'h5555_5555) begin errors++; $display("FAIL halt_ram_blocked: got %h want 55555555", d); end
      checks++; if (exit_code !== 32'h2A || halt !== 1'b1) begin errors++; $display("FAIL halt_tohost_blocked: got h=%b e=%h want h=1 e=2a", halt, exit_code); end
      cons_ready = 1'b1;
      #1;
      checks++; if (cons_data !== 8'h61) begin errors++; $display("FAIL halt_drain0: got %h want 61", cons_data); end
      tick();
      checks++; if (cons_data !== 8'h62) begin errors++; $display("FAIL halt_drain1: got %h want 62", cons_data); end
      tick();
      checks++; if (cons_valid !== 1'b0) begin errors++; $display("FAIL halt_drain_empty: got %b want 0", cons_valid); end
      cons_ready = 1'b0;
   endtask

   task automatic test_reset_mid();
      logic [31:0] d;
      apply_reset();
      cons_ready = 1'b0;
      wr(A_CONSOLE, 32'h31);
      wr(A_CONSOLE, 32'h32);
      wr(A_CONSOLE, 32'h33);
      wr(A_TOHOST, 32'h5);
      cons_ready = 1'b1;
      tick();
      checks++; if (cons_data !== 8'h32 || halt !== 1'b1) begin errors++; $display("FAIL mid_pre: got d=%h h=%b want d=32 h=1", cons_data, halt); end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      checks++; if (cons_valid !== 1'b0 || cons_data !== 8'h00) begin errors++; $display("FAIL mid_fifo: got v=%b d=%h want v=0 d=00", cons_valid, cons_data); end
      checks++; if (halt !== 1'b0 || exit_code !== 32'h0) begin errors++; $display("FAIL mid_halt: got h=%b e=%h want h=0 e=0", halt, exit_code); end
      rd(A_CYCLE, d);
      checks++; if (d !== 32'h0) begin errors++; $display("FAIL mid_cycle0: got %h want 0", d); end
      tick();
      rd(A_CYCLE, d);
      checks++; if (d !== 32'h1) begin errors++; $display("FAIL mid_cycle1: got %h want 1", d); end
      cons_ready = 1'b0;
   endtask

   initial begin
      reset      = 1'b1;
      MemWrite   = 1'b0;
      ALUResult  = '0;
      WriteData  = '0;
      cons_ready = 1'b0;
      test_reset();
      test_ram();
      test_console();
      test_overflow();
      test_counter();
      test_halt();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
